trigger_capture_buf: RTL and testbench

Parametrised successor to the single-shot trigger capture in the Tiny Logic Analyzer. It samples a WIDTH-bit input every cycle into a circular DEPTH-entry buffer and triggers on a masked pattern match, using either edge or level mode. After the trigger it captures a programmable number of post-trigger samples, then freezes and streams the window oldest-first over a valid/ready read port. It sits between the input synchroniser and the readout/serialiser logic.

---
 rtl/trigcap_pkg.sv | 14 +
 rtl/trigcap_match.sv | 29 ++
 rtl/trigger_capture_buf.sv | 168 ++++++++++++++++
 tb/tb_trigger_capture_buf.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigcap_pkg.sv
// Shared types for the trigger capture buffer.
// State encoding and timestamp width.
package trigcap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TS_W = 16;

endpackage

// File: rtl/trigcap_match.sv
// Masked pattern match with rising-edge detection.
// in: clk rst in_data pattern mask edge_mode; out: match trig_cond
module trigcap_match
  import trigcap_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             edge_mode,
  output logic             match,
  output logic             trig_cond
);

  logic match_prev;

  assign match = ((in_data & mask) == (pattern & mask));
  assign trig_cond = edge_mode ? (match & ~match_prev)
                               : match;

  always_ff @(posedge clk) begin
    if (rst) match_prev <= 1'b0;
    else     match_prev <= match;
  end

endmodule

// File: rtl/trigger_capture_buf.sv
// Circular trigger capture buffer with valid/ready oldest-first readout.
// Ports: arm/in_data/pattern/mask/edge_mode/post_len in; status + rd_* port.
// Optional TRIGCAP_TIMESTAMP_EN adds trig_time (counter latched at trigger).
module trigger_capture_buf
  import trigcap_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [WIDTH-1:0]  mask,
  input  logic              edge_mode,
  input  logic [ADDR_W-1:0] post_len,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   trig_index,
`ifdef TRIGCAP_TIMESTAMP_EN
  output logic [TS_W-1:0]   trig_time,
`endif
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic              rd_last
);

  localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t state_q, state_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [ADDR_W-1:0] post_rem_q, post_rem_d;
  logic [ADDR_W-1:0] post_lat_q, post_lat_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_ptr;
  logic              arm_prev;
  logic              we;
  logic              match;
  logic              trig_cond;
  logic              trig_hit;

  trigcap_match #(
    .WIDTH(WIDTH)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .pattern  (pattern),
    .mask     (mask),
    .edge_mode(edge_mode),
    .match    (match),
    .trig_cond(trig_cond)
  );

  // trig_cond already implies match; the extra term keeps the
  // qualifier visible where the trigger is consumed.
  assign trig_hit = arm & (state_q == PRE) & match & trig_cond;

  // Oldest retained sample sits fill entries behind the write pointer.
  assign rd_ptr = wr_ptr_q - fill_q[ADDR_W-1:0]
                + rd_cnt_q[ADDR_W-1:0];

  assign done       = (state_q == DONE);
  assign triggered  = (state_q == POST) | done;
  assign rd_valid   = done;
  assign rd_data    = mem[rd_ptr];
  assign rd_last    = done & (rd_cnt_q == fill_q - CNT_ONE);
  assign count      = done ? fill_q : '0;
  assign trig_index = done ? (fill_q - CNT_ONE - {1'b0, post_lat_q})
                           : '0;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_rem_d = post_rem_q;
    post_lat_d = post_lat_q;
    rd_cnt_d   = rd_cnt_q;
    we         = 1'b0;
    if (!arm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!arm_prev) begin
            state_d  = PRE;
            wr_ptr_d = '0;
            fill_d   = '0;
            rd_cnt_d = '0;
          end
        end
        PRE: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          fill_d   = (fill_q == FULL) ? fill_q
                                      : fill_q + CNT_ONE;
          if (trig_hit) begin
            post_lat_d = post_len;
            post_rem_d = post_len;
            state_d    = (post_len == '0) ? DONE : POST;
          end
        end
        POST: begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          fill_d     = (fill_q == FULL) ? fill_q
                                        : fill_q + CNT_ONE;
          post_rem_d = post_rem_q - PTR_ONE;
          if (post_rem_q == PTR_ONE) state_d = DONE;
        end
        DONE: begin
          if (rd_ready) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
            if (rd_last) state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_rem_q <= '0;
      post_lat_q <= '0;
      rd_cnt_q   <= '0;
      arm_prev   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_rem_q <= post_rem_d;
      post_lat_q <= post_lat_d;
      rd_cnt_q   <= rd_cnt_d;
      arm_prev   <= arm;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= in_data;
  end

`ifdef TRIGCAP_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q      <= '0;
      trig_time <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (trig_hit) trig_time <= ts_q;
    end
  end
`endif

endmodule

// File: tb/tb_trigger_capture_buf.sv
// Randomised scoreboard bench for trigger_capture_buf.
// WIDTH=4, DEPTH=8; monitor pops expected window samples on each transfer.
module tb_trigger_capture_buf;
  import trigcap_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [W-1:0]  in_data;
  logic [W-1:0]  pattern;
  logic [W-1:0]  mask;
  logic          edge_mode;
  logic [AW-1:0] post_len;
  logic          triggered;
  logic          done;
  logic [AW:0]   count;
  logic [AW:0]   trig_index;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_ready = 1'b0;
  logic          rd_last;
`ifdef TRIGCAP_TIMESTAMP_EN
  logic [TS_W-1:0] trig_time;
  logic [TS_W-1:0] ts_model;
  always @(posedge clk) ts_model <= rst ? '0 : ts_model + 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] data;
    bit           last;
    int           cnt;
    int           tidx;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] stim_q[$];
  bit           mprev;

  always #5 clk = ~clk;

  trigger_capture_buf #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .in_data   (in_data),
    .pattern   (pattern),
    .mask      (mask),
    .edge_mode (edge_mode),
    .post_len  (post_len),
    .triggered (triggered),
    .done      (done),
    .count     (count),
    .trig_index(trig_index),
`ifdef TRIGCAP_TIMESTAMP_EN
    .trig_time (trig_time),
`endif
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit mt(input logic [W-1:0] d);
    return ((d & mask) == (pattern & mask));
  endfunction

  function automatic logic [W-1:0] next_d();
    if (stim_q.size() != 0) return stim_q.pop_front();
    return W'($urandom);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] d, input logic a);
    in_data = d;
    arm     = a;
    mprev   = mt(d);
  endtask

  // Checks readout: every valid cycle must show the queue head; a
  // stalled beat therefore has to stay put until it is accepted.
  always @(negedge clk) begin
    bit rdy;
    rdy = ($urandom_range(0, 2) != 0);
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        chk("rd_data", rd_data, sb[0].data);
        chk("rd_last", rd_last, sb[0].last);
        chk("count", count, sb[0].cnt);
        chk("trig_index", trig_index, sb[0].tidx);
        if (rdy) void'(sb.pop_front());
      end
    end
    rd_ready = rdy;
  end

  task automatic capture(input bit em, input logic [W-1:0] pt,
                         input logic [W-1:0] mk, input logic [AW-1:0] pl,
                         input int abort_post, input int max_pre);
    logic [W-1:0] win[$];
    logic [W-1:0] d;
    bit tc, trig, chk_trg, fin;
    int posts, pre, n, k;
    logic [15:0] exp_tt;
    exp_tt = '0;
    tick();
    edge_mode = em; pattern = pt; mask = mk; post_len = pl;
    drive(next_d(), 1'b0);
    tick(); drive(next_d(), 1'b0);
    tick(); drive(next_d(), 1'b1);
    trig = 0; chk_trg = 0; posts = 0; pre = 0;
    while (1) begin
      tick();
      if (chk_trg) begin
        chk("triggered", triggered, 1);
`ifdef TRIGCAP_TIMESTAMP_EN
        chk("trig_time", trig_time, exp_tt);
`endif
        chk_trg = 0;
      end
      if (!trig && pre >= max_pre) begin
        chk("no_trigger", triggered, 0);
        drive(next_d(), 1'b0);
        stim_q.delete();
        return;
      end
      if (trig && abort_post >= 0 && posts == abort_post) begin
        drive(next_d(), 1'b0);
        tick();
        chk("abort_done", done, 0);
        chk("abort_valid", rd_valid, 0);
        chk("abort_trig", triggered, 0);
        chk("abort_count", count, 0);
        stim_q.delete();
        return;
      end
      d  = next_d();
      tc = em ? (mt(d) && !mprev) : mt(d);
      drive(d, 1'b1);
      win.push_back(d);
      if (trig) posts++;
      else if (tc) begin
        trig = 1; chk_trg = 1;
`ifdef TRIGCAP_TIMESTAMP_EN
        exp_tt = ts_model;
`endif
      end else pre++;
      if (trig && posts == int'(pl)) break;
    end
    n = win.size();
    k = (n < D) ? n : D;
    for (int i = n - k; i < n; i++)
      sb.push_back('{win[i], (i == n - 1), k, k - 1 - int'(pl)});
    fin = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (chk_trg) begin
        chk("triggered", triggered, 1);
`ifdef TRIGCAP_TIMESTAMP_EN
        chk("trig_time", trig_time, exp_tt);
`endif
        chk_trg = 0;
      end
      if (sb.size() == 0 && done == 1'b0) begin
        fin = 1;
        break;
      end
      drive(next_d(), 1'b1);
    end
    if (!fin) begin
      chk("readout_timeout", 1, 0);
      sb.delete();
    end
    // arm still high after readout: no restart allowed
    for (int c = 0; c < 3; c++) begin
      drive(next_d(), 1'b1);
      tick();
    end
    chk("rearm_done", done, 0);
    chk("rearm_trig", triggered, 0);
`ifdef TRIGCAP_TIMESTAMP_EN
    chk("trig_time_hold", trig_time, exp_tt);
`endif
    drive(next_d(), 1'b0);
    stim_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b1; in_data = '0;
    pattern = 4'hA; mask = 4'hF; edge_mode = 1'b0; post_len = '0;
    repeat (3) begin
      tick();
      in_data = W'($urandom);
    end
    tick();
    chk("rst_triggered", triggered, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_trig_index", trig_index, 0);
    chk("rst_rd_last", rd_last, 0);
    rst = 1'b0;
    drive(4'h1, 1'b0);
    tick(); drive(4'h1, 1'b1);
    tick(); drive(4'h2, 1'b1);
    tick(); drive(4'h3, 1'b1);
    tick(); rst = 1'b1; drive(4'hA, 1'b1); mprev = 0;
    tick();
    chk("midrst_triggered", triggered, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_count", count, 0);
    rst = 1'b0;
    drive(4'h5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("postrst_rd_valid", rd_valid, 0);
      chk("postrst_triggered", triggered, 0);
      drive(4'h5, 1'b1);
    end
    tick(); drive(4'h5, 1'b0);

    stim_q = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'hA,
               4'h5, 4'h6, 4'h7};
    capture(1'b1, 4'hA, 4'hF, 3'd2, -1, 20);

    stim_q = '{4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 16; i++) stim_q.push_back(W'(i));
    capture(1'b0, 4'hC, 4'hF, 3'd3, -1, 30);

    for (int i = 0; i < 13; i++) stim_q.push_back(4'hA);
    capture(1'b1, 4'hA, 4'hF, 3'd5, -1, 10);

    stim_q = '{4'hA, 4'hA, 4'hA, 4'hA};
    capture(1'b0, 4'hA, 4'hF, 3'd0, -1, 10);

    stim_q = '{4'h0, 4'h0, 4'h0};
    capture(1'b0, 4'h0, 4'h0, 3'd7, 2, 10);

    for (int t = 0; t < 25; t++)
      capture(1'($urandom), W'($urandom), W'($urandom),
              AW'($urandom), -1, 40);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
